// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for the shared synchronous memory port
//
// Shares one memory port (one-cycle read latency) between requester 0 (core)
// and requester 1 (loader/debug). Ownership is round-robin with a bounded hold:
// an owner that keeps requesting while the other side waits is forced off after
// MAX_HOLD accesses. Read data is steered back to whichever requester issued the
// read, even if ownership has already moved on by the time the data returns.
//
// Ports:
//   clk, reset                 clock (rising edge) and asynchronous active-low reset
//   m0_*/m1_* req,we,addr,     requester access, held stable until granted
//       wdata,funct3
//   m0_gnt, m1_gnt             requester owns the port this cycle
//   m0_rvalid, m1_rvalid       read data for that requester is valid this cycle
//   m0_rdata, m1_rdata         memory read data fanned out to both requesters
//   mem_addr, mem_wren,        memory request side
//       mem_wdata, mem_funct3
//   mem_rdata                  memory read data, valid one cycle after a read

module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_funct3,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_funct3,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last;        // 0: requester 0 owned last, 1: requester 1
    logic              last_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              rvalid0;
    logic              rvalid1;

    logic own0;
    logic own1;
    logic issue0;
    logic issue1;
    logic hold_hit;
    logic contended;

    assign own0     = (state == ST_OWN0);
    assign own1     = (state == ST_OWN1);
    assign issue0   = own0 & m0_req;
    assign issue1   = own1 & m1_req;
    assign hold_hit = (hold_cnt == HOLD_LAST);

    // An access counts toward the hold limit only while the other side waits.
    assign contended = (issue0 & m1_req) | (issue1 & m0_req);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt = last ? ST_OWN0 : ST_OWN1;
                end else if (m0_req) begin
                    state_nxt = ST_OWN0;
                end else if (m1_req) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_req) begin
                    state_nxt = m1_req ? ST_OWN1 : ST_IDLE;
                end else if (m1_req && hold_hit) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!m1_req) begin
                    state_nxt = m0_req ? ST_OWN0 : ST_IDLE;
                end else if (m0_req && hold_hit) begin
                    state_nxt = ST_OWN0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_nxt = hold_cnt;
        last_nxt = last;
        if (state_nxt != state) begin
            hold_nxt = '0;
            if (own0) begin
                last_nxt = 1'b0;
            end else if (own1) begin
                last_nxt = 1'b1;
            end
        end else if (contended) begin
            hold_nxt = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            last     <= 1'b1;       // requester 0 wins the first tie
            hold_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            // Return tags follow the issuer, not the current owner.
            rvalid0  <= issue0 & ~m0_we;
            rvalid1  <= issue1 & ~m1_we;
        end
    end

    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = 3'd0;
        mem_wren   = 1'b0;
        if (own0) begin
            mem_addr   = m0_addr;
            mem_wdata  = m0_wdata;
            mem_funct3 = m0_funct3;
            mem_wren   = issue0 & m0_we;
        end else if (own1) begin
            mem_addr   = m1_addr;
            mem_wdata  = m1_wdata;
            mem_funct3 = m1_funct3;
            mem_wren   = issue1 & m1_we;
        end
    end

    assign m0_gnt    = own0;
    assign m1_gnt    = own1;
    assign m0_rvalid = rvalid0;
    assign m1_rvalid = rvalid1;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule
